// File: rtl/pd_pluse_sched.sv
// pd_pluse_sched: host-facing sequencer for the pd_pluse generator chain.
// Holds a shadow table of timing words, streams it into the generator on arm,
// then fires pluse_start repeatedly, paced by the generator's en output.
module pd_pluse_sched #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned REP_W    = 16,
    parameter int unsigned LOAD_GAP = 2,
    parameter int unsigned START_W  = 4,
    parameter int unsigned TMO_W    = 24
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              host_we,
    input  logic [3:0]        host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    input  logic [4:0]        cfg_nregs,
    input  logic [REP_W-1:0]  rep_count,
    input  logic [TMO_W-1:0]  timeout_lim,
    input  logic              arm,
    input  logic              abort,
    input  logic              en_in,
    output logic              pd_pluse_load,
    output logic [3:0]        pd_pluse_choice,
    output logic [DATA_W-1:0] pd_pluse_data,
    output logic              pluse_start,
    output logic              busy,
    output logic              seq_done,
    output logic [REP_W-1:0]  rep_cur,
    output logic              timeout_err,
    output logic              wr_err
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_START,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [REP_W-1:0]    rep_q, rep_d;
    logic [3:0]          choice_q, choice_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                tmo_err_q, tmo_err_d;
    logic                wr_err_q, wr_err_d;
    logic                load_q, load_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   shadow_q [NUM_REGS];
    logic [DATA_W-1:0]   shadow_d [NUM_REGS];
    logic                en_meta_q, en_s_q;

    logic [4:0]          nregs_eff;
    logic [4:0]          idx_inc;
    logic                load_more;
    logic [TMO_W-1:0]    tmo_inc;
    logic                tmo_hit;
    logic [REP_W-1:0]    rep_inc;
    logic                adv;

    // Two-flop synchroniser for the generator's en (dds clock domain)
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            en_meta_q <= 1'b0;
            en_s_q    <= 1'b0;
        end else begin
            en_meta_q <= en_in;
            en_s_q    <= en_meta_q;
        end
    end

    // Derived arithmetic shared by the next-state logic
    always_comb begin
        nregs_eff = (cfg_nregs > 5'(NUM_REGS)) ? 5'(NUM_REGS) : cfg_nregs;
        idx_inc   = idx_q + 5'd1;
        load_more = (idx_inc < nregs_eff);
        tmo_inc   = tmo_q + TMO_W'(1);
        tmo_hit   = (timeout_lim != '0) && (tmo_inc == timeout_lim);
        rep_inc   = rep_q + REP_W'(1);
    end

    // Next-state, counters, shadow table writes and registered outputs
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        rep_d     = rep_q;
        choice_d  = choice_q;
        data_d    = data_q;
        tmo_err_d = tmo_err_q;
        wr_err_d  = wr_err_q;
        shadow_d  = shadow_q;
        rdata_d   = shadow_q[host_addr];
        adv       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arm && !abort) begin
                    rep_d     = '0;
                    tmo_err_d = 1'b0;
                    wr_err_d  = 1'b0;
                    idx_d     = '0;
                    cnt_d     = '0;
                    if (nregs_eff != '0) begin
                        state_d  = ST_LOAD;
                        choice_d = '0;
                        data_d   = shadow_q[0];
                    end else begin
                        state_d = ST_START;
                    end
                end
            end
            ST_LOAD: begin
                cnt_d = '0;
                if (LOAD_GAP == 0) adv = 1'b1;
                else               state_d = ST_GAP;
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(LOAD_GAP - 1)) adv = 1'b1;
                else                               cnt_d = cnt_q + CNT_W'(1);
            end
            ST_START: begin
                if (cnt_q == CNT_W'(START_W - 1)) begin
                    state_d = ST_WAIT_HI;
                    tmo_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_HI: begin
                if (en_s_q) begin
                    state_d = ST_WAIT_LO;
                    tmo_d   = '0;
                end else if (tmo_hit) begin
                    state_d   = ST_IDLE;
                    tmo_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            ST_WAIT_LO: begin
                if (!en_s_q) begin
                    rep_d   = rep_inc;
                    cnt_d   = '0;
                    state_d = ((rep_count != '0) && (rep_inc == rep_count)) ? ST_DONE : ST_START;
                end else if (tmo_hit) begin
                    state_d   = ST_IDLE;
                    tmo_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // End of a load gap: either load the next index or move on to START
        if (adv) begin
            if (load_more) begin
                state_d  = ST_LOAD;
                idx_d    = idx_inc;
                choice_d = idx_inc[3:0];
                data_d   = shadow_q[idx_inc[3:0]];
            end else begin
                state_d = ST_START;
                cnt_d   = '0;
            end
        end

        // Abort overrides whatever the state logic decided, keeping rep_cur and flags
        if ((state_q != ST_IDLE) && abort) begin
            state_d   = ST_IDLE;
            rep_d     = rep_q;
            tmo_err_d = tmo_err_q;
        end

        if (host_we) begin
            if (state_q == ST_IDLE) shadow_d[host_addr] = host_wdata;
            else                    wr_err_d = 1'b1;
        end

        load_d  = (state_d == ST_LOAD);
        start_d = (state_d == ST_START);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // Sequencer state, counters and registered outputs
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            rep_q     <= '0;
            choice_q  <= '0;
            data_q    <= '0;
            tmo_err_q <= 1'b0;
            wr_err_q  <= 1'b0;
            load_q    <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            rep_q     <= rep_d;
            choice_q  <= choice_d;
            data_q    <= data_d;
            tmo_err_q <= tmo_err_d;
            wr_err_q  <= wr_err_d;
            load_q    <= load_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
        end
    end

    // Shadow table storage, cleared by reset
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign host_rdata      = rdata_q;
    assign pd_pluse_load   = load_q;
    assign pd_pluse_choice = choice_q;
    assign pd_pluse_data   = data_q;
    assign pluse_start     = start_q;
    assign busy            = busy_q;
    assign seq_done        = done_q;
    assign rep_cur         = rep_q;
    assign timeout_err     = tmo_err_q;
    assign wr_err          = wr_err_q;

endmodule

// File: tb/tb_pd_pluse_sched.sv
// Self-checking bench for pd_pluse_sched: vector table, randomized runs against
// an event-level model, and hand-written corner-case sequences.
module tb_pd_pluse_sched;

    localparam int unsigned LOAD_GAP = 2;
    localparam int unsigned START_W  = 4;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic        host_we = 1'b0;
    logic [3:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic [15:0] host_rdata;
    logic [4:0]  cfg_nregs = '0;
    logic [15:0] rep_count = '0;
    logic [23:0] timeout_lim = '0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        en_in = 1'b0;
    logic        pd_pluse_load;
    logic [3:0]  pd_pluse_choice;
    logic [15:0] pd_pluse_data;
    logic        pluse_start;
    logic        busy;
    logic        seq_done;
    logic [15:0] rep_cur;
    logic        timeout_err;
    logic        wr_err;

    pd_pluse_sched #(
        .NUM_REGS(16), .DATA_W(16), .REP_W(16),
        .LOAD_GAP(LOAD_GAP), .START_W(START_W), .TMO_W(24)
    ) dut (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata),
        .cfg_nregs(cfg_nregs), .rep_count(rep_count), .timeout_lim(timeout_lim),
        .arm(arm), .abort(abort), .en_in(en_in),
        .pd_pluse_load(pd_pluse_load), .pd_pluse_choice(pd_pluse_choice),
        .pd_pluse_data(pd_pluse_data), .pluse_start(pluse_start),
        .busy(busy), .seq_done(seq_done), .rep_cur(rep_cur),
        .timeout_err(timeout_err), .wr_err(wr_err)
    );

    always #5 clk_sys = ~clk_sys;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference shadow table
    logic [15:0] shadow_m [16];

    // Generator stand-in: en pulse after each pluse_start rise
    bit en_auto = 1'b0;
    int en_dly  = 2;
    int en_hi   = 8;

    always begin
        @(negedge clk_sys);
        if (en_auto && pluse_start) begin
            repeat (en_dly) @(negedge clk_sys);
            #1 en_in = 1'b1;
            repeat (en_hi) @(negedge clk_sys);
            #1 en_in = 1'b0;
            while (pluse_start) @(negedge clk_sys);
        end
    end

    // Event monitor sampled on the falling edge
    int          cyc = 0;
    int          load_cyc [$];
    logic [3:0]  load_ch  [$];
    logic [15:0] load_dt  [$];
    int starts, start_badw, first_start, start_w, done_cnt, done_cyc, idle_cyc, tmo_cyc;
    logic start_prev = 1'b0, busy_prev = 1'b0, tmo_prev = 1'b0;

    always @(negedge clk_sys) begin
        cyc++;
        if (pd_pluse_load) begin
            load_cyc.push_back(cyc);
            load_ch.push_back(pd_pluse_choice);
            load_dt.push_back(pd_pluse_data);
        end
        if (pluse_start) begin
            if (!start_prev) begin
                starts++;
                if (first_start < 0) first_start = cyc;
                start_w = 0;
            end
            start_w++;
        end else if (start_prev && start_w != int'(START_W)) begin
            start_badw++;
        end
        if (seq_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy_prev && !busy) idle_cyc = cyc;
        if (timeout_err && !tmo_prev) tmo_cyc = cyc;
        start_prev = pluse_start;
        busy_prev  = busy;
        tmo_prev   = timeout_err;
    end

    task automatic clr_stats();
        load_cyc.delete(); load_ch.delete(); load_dt.delete();
        starts = 0; start_badw = 0; first_start = -1; start_w = 0;
        done_cnt = 0; done_cyc = -1; idle_cyc = -1; tmo_cyc = -1;
    endtask

    task automatic tick();
        @(negedge clk_sys);
        #1;
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [15:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        tick();
        host_we = 1'b0;
    endtask

    task automatic do_arm(output int ac);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        ac = cyc;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        chk({nm, "_finish_in_budget"}, {31'd0, busy}, 32'd0);
    endtask

    // Full normal run: expected events come from the table / model arguments
    task automatic run_normal(input string nm, input int n, input int reps, input int lim,
                              input int exp_loads, input int exp_reps);
        int ac;
        int bad = 0;
        cfg_nregs = 5'(n); rep_count = 16'(reps); timeout_lim = 24'(lim);
        en_auto = 1'b1;
        clr_stats();
        do_arm(ac);
        wait_idle(20000, nm);
        chk({nm, "_nloads"}, load_cyc.size(), exp_loads);
        for (int k = 0; k < load_cyc.size() && k < exp_loads; k++) begin
            if (load_ch[k] != 4'(k) || load_dt[k] != shadow_m[k] ||
                load_cyc[k] != ac + k * int'(1 + LOAD_GAP)) bad++;
        end
        chk({nm, "_load_seq_errs"}, bad, 0);
        chk({nm, "_start_latency"}, first_start - ac, exp_loads * int'(1 + LOAD_GAP));
        chk({nm, "_nstarts"}, starts, exp_reps);
        chk({nm, "_start_width_errs"}, start_badw, 0);
        chk({nm, "_done_cycles"}, done_cnt, 1);
        chk({nm, "_idle_after_done"}, idle_cyc - done_cyc, 1);
        chk({nm, "_rep_cur"}, rep_cur, exp_reps);
        chk({nm, "_no_timeout"}, timeout_err, 0);
        tick();
    endtask

    typedef struct {
        int n;
        int reps;
        int dly;
        int hi;
        int exp_loads;
        int exp_reps;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ac;
        int k;

        tbl[0] = '{3, 1, 3, 8, 3, 1};
        tbl[1] = '{0, 3, 2, 50, 0, 3};
        tbl[2] = '{20, 1, 4, 10, 16, 1};
        tbl[3] = '{16, 2, 1, 6, 16, 2};
        tbl[4] = '{1, 2, 10, 20, 1, 2};

        for (int i = 0; i < 16; i++) shadow_m[i] = '0;
        clr_stats();
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_load", pd_pluse_load, 0);
        chk("reset_start", pluse_start, 0);
        chk("reset_rdata", host_rdata, 0);
        chk("reset_flags", {timeout_err, wr_err, seq_done}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            host_wr(4'(i), 16'(16'h1000 + i));
            shadow_m[i] = 16'(16'h1000 + i);
        end

        // Vector table
        for (int i = 0; i < 5; i++) begin
            en_dly = tbl[i].dly;
            en_hi  = tbl[i].hi;
            run_normal($sformatf("vec%0d", i), tbl[i].n, tbl[i].reps, 0,
                       tbl[i].exp_loads, tbl[i].exp_reps);
        end

        // Randomized runs against the model
        for (int i = 0; i < 8; i++) begin
            int n, reps, lim;
            for (int w = 0; w < 3; w++) begin
                logic [3:0]  a;
                logic [15:0] d;
                a = 4'($urandom_range(0, 15));
                d = 16'($urandom);
                host_wr(a, d);
                shadow_m[a] = d;
            end
            n      = int'($urandom_range(0, 20));
            reps   = int'($urandom_range(1, 4));
            en_dly = int'($urandom_range(1, 10));
            en_hi  = int'($urandom_range(6, 20));
            lim    = ($urandom_range(0, 1) == 0) ? 0 : 200;
            run_normal($sformatf("rnd%0d", i), n, reps, lim, (n > 16) ? 16 : n, reps);
        end

        // Host read-back and write-while-busy
        host_wr(4'd7, 16'hBEEF);
        shadow_m[7] = 16'hBEEF;
        host_addr = 4'd7;
        tick();
        chk("host_readback", host_rdata, 16'hBEEF);
        cfg_nregs = 5'd0; rep_count = 16'd1; timeout_lim = '0;
        en_auto = 1'b1; en_dly = 10; en_hi = 10;
        clr_stats();
        do_arm(ac);
        host_wr(4'd7, 16'h1234);
        chk("wr_err_set", wr_err, 1);
        wait_idle(2000, "wr_busy");
        host_addr = 4'd7;
        tick();
        chk("wr_busy_dropped", host_rdata, shadow_m[7]);
        clr_stats();
        do_arm(ac);
        chk("wr_err_cleared_on_arm", wr_err, 0);
        wait_idle(2000, "wr_rearm");

        // Timeout with en held low
        cfg_nregs = 5'd0; rep_count = 16'd1; timeout_lim = 24'd100;
        en_auto = 1'b0;
        repeat (5) tick();
        clr_stats();
        do_arm(ac);
        wait_idle(400, "tmo");
        chk("tmo_flag", timeout_err, 1);
        chk("tmo_latency", tmo_cyc - first_start, int'(START_W) + 100);
        chk("tmo_idle_same_cycle", idle_cyc, tmo_cyc);
        chk("tmo_no_done", done_cnt, 0);
        timeout_lim = '0;
        en_auto = 1'b1; en_dly = 2; en_hi = 8;
        clr_stats();
        do_arm(ac);
        chk("tmo_cleared_on_arm", timeout_err, 0);
        wait_idle(2000, "tmo_rearm");
        chk("tmo_rearm_done", done_cnt, 1);

        // Abort after 5 repetitions of an endless run
        cfg_nregs = 5'd0; rep_count = 16'd0;
        clr_stats();
        do_arm(ac);
        k = 0;
        while (rep_cur != 16'd5 && k < 5000) begin
            tick();
            k++;
        end
        chk("abort_reached_5", rep_cur, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", busy, 0);
        chk("abort_start_low", pluse_start, 0);
        chk("abort_rep_cur", rep_cur, 5);
        chk("abort_no_done", done_cnt, 0);
        repeat (40) tick();
        chk("abort_rep_hold", rep_cur, 5);

        // arm and abort together in IDLE
        cfg_nregs = 5'd2; rep_count = 16'd1;
        clr_stats();
        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        chk("arm_abort_idle", busy, 0);
        repeat (10) tick();
        chk("arm_abort_no_start", starts, 0);
        chk("arm_abort_no_load", load_cyc.size(), 0);

        // Asynchronous reset in the middle of LOAD
        cfg_nregs = 5'd16; rep_count = 16'd1;
        clr_stats();
        do_arm(ac);
        chk("rst_pre_load", pd_pluse_load, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_load", pd_pluse_load, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_choice_data", {pd_pluse_choice, pd_pluse_data}, 0);
        chk("rst_async_misc", {pluse_start, seq_done, timeout_err, wr_err, rep_cur}, 0);
        for (int i = 0; i < 16; i++) shadow_m[i] = '0;
        tick();
        rst_n = 1'b1;
        host_addr = 4'd5;
        tick();
        chk("rst_shadow_cleared", host_rdata, shadow_m[5]);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
